// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes and the ID/EX payload for the operand-fetch stage.
package id_ex_stage_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 4;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SRA  = 4'h8,
        ALU_LUI  = 4'h9
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [RW-1:0]   rd;
        logic [OPW-1:0]  aluop;
        logic [DW-1:0]   opa;
        logic [DW-1:0]   opb;
        logic [DW-1:0]   store_data;
    } ex_pl_t;

    // Bubble: no valid instruction, no side effects, zeroed data.
    localparam ex_pl_t EX_BUBBLE = '0;

    function automatic logic [NREG-1:0] onehot_sel(input logic [RW-1:0] idx);
        onehot_sel      = '0;
        onehot_sel[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding: r0 -> 0, then EX/MEM (younger), then MEM/WB, else register-file bus.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [RW-1:0] idx_i,
    input  logic [DW-1:0] bus_i,
    input  logic          exmem_we_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_data_i,
    input  logic          memwb_we_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_data_i,
    output logic [DW-1:0] fwd_c
);

    always_comb begin
        fwd_c = bus_i;
        if (idx_i == '0) begin
            fwd_c = '0;
        end else if (exmem_we_i && (exmem_rd_i == idx_i)) begin
            fwd_c = exmem_data_i;
        end else if (memwb_we_i && (memwb_rd_i == idx_i)) begin
            fwd_c = memwb_data_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: register-file select decode, forwarding, load-use stall and the EX pipeline register.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned CNTW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [RW-1:0]      in_rs,
    input  logic [RW-1:0]      in_rt,
    input  logic [RW-1:0]      in_rd,
    input  logic [DW-1:0]      in_imm,
    input  logic [OPW-1:0]     in_aluop,
    input  logic               in_use_imm,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_reg_write,
    output logic [NREG-1:0]    asel,
    output logic [NREG-1:0]    bsel,
    input  logic [DW-1:0]      abus,
    input  logic [DW-1:0]      bbus,
    input  logic               exmem_reg_write,
    input  logic [RW-1:0]      exmem_rd,
    input  logic [DW-1:0]      exmem_data,
    input  logic               memwb_reg_write,
    input  logic [RW-1:0]      memwb_rd,
    input  logic [DW-1:0]      memwb_data,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic [DW-1:0]      ex_opa,
    output logic [DW-1:0]      ex_opb,
    output logic [DW-1:0]      ex_store_data,
    output logic [RW-1:0]      ex_rd,
    output logic [OPW-1:0]     ex_aluop,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic [CNTW-1:0]    stall_count
);

    ex_pl_t            ex_q, ex_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     fwd_a, fwd_b;
    logic              hz;

    // Register 0 is hard-wired, so its select is never driven.
    always_comb begin
        asel = '0;
        bsel = '0;
        if (in_valid && (in_rs != '0)) asel = onehot_sel(in_rs);
        if (in_valid && (in_rt != '0)) bsel = onehot_sel(in_rt);
    end

    id_ex_stage_fwd_mux u_fwd_a (
        .idx_i        (in_rs),
        .bus_i        (abus),
        .exmem_we_i   (exmem_reg_write),
        .exmem_rd_i   (exmem_rd),
        .exmem_data_i (exmem_data),
        .memwb_we_i   (memwb_reg_write),
        .memwb_rd_i   (memwb_rd),
        .memwb_data_i (memwb_data),
        .fwd_c        (fwd_a)
    );

    id_ex_stage_fwd_mux u_fwd_b (
        .idx_i        (in_rt),
        .bus_i        (bbus),
        .exmem_we_i   (exmem_reg_write),
        .exmem_rd_i   (exmem_rd),
        .exmem_data_i (exmem_data),
        .memwb_we_i   (memwb_reg_write),
        .memwb_rd_i   (memwb_rd),
        .memwb_data_i (memwb_data),
        .fwd_c        (fwd_b)
    );

    // rt only matters for the hazard when it is actually read as a register.
    always_comb begin
        hz = in_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
             ((ex_q.rd == in_rs) ||
              ((ex_q.rd == in_rt) && (!in_use_imm || in_mem_write)));
        stall = hz && !flush;
    end

    always_comb begin
        ex_d  = EX_BUBBLE;
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
        if (!flush && !hz && in_valid) begin
            ex_d.valid      = 1'b1;
            ex_d.mem_read   = in_mem_read;
            ex_d.mem_write  = in_mem_write;
            ex_d.reg_write  = in_reg_write;
            ex_d.rd         = in_rd;
            ex_d.aluop      = in_aluop;
            ex_d.opa        = fwd_a;
            ex_d.opb        = in_use_imm ? in_imm : fwd_b;
            ex_d.store_data = fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= EX_BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_opa        = ex_q.opa;
    assign ex_opb        = ex_q.opb;
    assign ex_store_data = ex_q.store_data;
    assign ex_rd         = ex_q.rd;
    assign ex_aluop      = ex_q.aluop;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign stall_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, random traffic against a reference model, counter saturation.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned TB_CNTW = 8;
    localparam int unsigned CMAX    = (1 << TB_CNTW) - 1;

    logic clk = 1'b0;
    logic reset, in_valid, in_use_imm, in_mem_read, in_mem_write, in_reg_write, flush;
    logic [4:0] in_rs, in_rt, in_rd, exmem_rd, memwb_rd;
    logic [31:0] in_imm, exmem_data, memwb_data, abus, bbus, junk_a, junk_b;
    logic [3:0] in_aluop;
    logic exmem_reg_write, memwb_reg_write;
    logic [31:0] asel, bsel, ex_opa, ex_opb, ex_store_data;
    logic stall, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [4:0] ex_rd;
    logic [3:0] ex_aluop;
    logic [TB_CNTW-1:0] stall_count;

    logic [31:0] regs [32];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNTW(TB_CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_imm(in_imm), .in_aluop(in_aluop), .in_use_imm(in_use_imm),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_reg_write(in_reg_write),
        .asel(asel), .bsel(bsel), .abus(abus), .bbus(bbus),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_aluop(ex_aluop),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .stall_count(stall_count)
    );

    // Register file: drives the bus named by the one-hot select, garbage when none is set.
    always_comb begin
        abus = junk_a;
        bbus = junk_b;
        for (int i = 1; i < 32; i++) begin
            if (asel[i]) abus = regs[i];
            if (bsel[i]) bbus = regs[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of what EX should hold after the next edge.
    logic m_valid, m_mr, m_mw, m_rw, m_dchk;
    logic [4:0] m_rd;
    logic [3:0] m_op;
    logic [31:0] m_opa, m_opb, m_sd;
    int unsigned m_cnt;

    function automatic logic [31:0] model_fwd(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (exmem_reg_write && exmem_rd == idx) return exmem_data;
        if (memwb_reg_write && memwb_rd == idx) return memwb_data;
        return regs[idx];
    endfunction

    task automatic run_cycle();
        logic [31:0] xa, xb, fb;
        logic hz;
        #2;
        xa = (in_valid && in_rs != 0) ? (32'd1 << in_rs) : 32'd0;
        xb = (in_valid && in_rt != 0) ? (32'd1 << in_rt) : 32'd0;
        hz = in_valid && m_valid && m_mr && (m_rd != 0) &&
             (m_rd == in_rs || (m_rd == in_rt && (!in_use_imm || in_mem_write)));
        chk("m_asel", asel, xa);
        chk("m_bsel", bsel, xb);
        chk("m_stall", stall, hz && !flush);
        if (reset) begin
            {m_valid, m_mr, m_mw, m_rw, m_rd, m_op, m_opa, m_opb, m_sd} = '0;
            m_cnt = 0; m_dchk = 1'b1;
        end else begin
            if (hz && !flush && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (flush || hz || !in_valid) begin
                {m_valid, m_mr, m_mw, m_rw, m_rd, m_op, m_opa, m_opb, m_sd} = '0;
                m_dchk = flush || hz;
            end else begin
                fb = model_fwd(in_rt);
                m_valid = 1'b1; m_mr = in_mem_read; m_mw = in_mem_write; m_rw = in_reg_write;
                m_rd = in_rd; m_op = in_aluop; m_opa = model_fwd(in_rs);
                m_opb = in_use_imm ? in_imm : fb; m_sd = fb; m_dchk = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("m_ex_valid", ex_valid, m_valid);
        chk("m_ex_mem_read", ex_mem_read, m_mr);
        chk("m_ex_mem_write", ex_mem_write, m_mw);
        chk("m_ex_reg_write", ex_reg_write, m_rw);
        chk("m_stall_count", stall_count, m_cnt);
        if (m_dchk) begin
            chk("m_ex_opa", ex_opa, m_opa);
            chk("m_ex_opb", ex_opb, m_opb);
            chk("m_ex_store_data", ex_store_data, m_sd);
            chk("m_ex_rd", ex_rd, m_rd);
            chk("m_ex_aluop", ex_aluop, m_op);
        end
    endtask

    typedef struct {
        logic rst, fl, v, ui, mr, mw, rw, ew, mwe;
        logic [4:0] rs, rt, rd, erd, mrd;
        logic [31:0] imm, ed, md;
        logic [3:0] op;
        logic [31:0] x_asel, x_bsel;
        logic x_stall, x_valid;
        logic [31:0] x_opa, x_opb, x_sd;
        int unsigned x_cnt;
    } vec_t;

    vec_t vt[$];

    task automatic apply(input vec_t a);
        reset = a.rst; flush = a.fl; in_valid = a.v; in_rs = a.rs; in_rt = a.rt; in_rd = a.rd;
        in_imm = a.imm; in_aluop = a.op; in_use_imm = a.ui; in_mem_read = a.mr;
        in_mem_write = a.mw; in_reg_write = a.rw;
        exmem_reg_write = a.ew; exmem_rd = a.erd; exmem_data = a.ed;
        memwb_reg_write = a.mwe; memwb_rd = a.mrd; memwb_data = a.md;
    endtask

    task automatic load_vec(output vec_t v);
        v = '{default: '0};
        v.v = 1'b1; v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd9; v.mr = 1'b1; v.rw = 1'b1;
    endtask

    initial begin
        vec_t v, ld, dep;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | 32'(i);
        regs[1] = 32'h101; regs[2] = 32'h202; regs[3] = 32'h11; regs[4] = 32'h22;
        regs[5] = 32'h55;  regs[9] = 32'h99;
        junk_a = 32'hDEAD_BEEF; junk_b = 32'hBAD0_CAFE;
        {m_valid, m_mr, m_mw, m_rw, m_rd, m_op, m_opa, m_opb, m_sd} = '0;
        m_cnt = 0; m_dchk = 1'b0;

        load_vec(ld);
        dep = '{default: '0};
        dep.v = 1'b1; dep.rs = 5'd9; dep.rt = 5'd3; dep.rd = 5'd10; dep.rw = 1'b1;

        v = '{default: '0}; v.rst = 1'b1; vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rs = 3; v.rt = 4; v.rd = 6; v.op = 2; v.rw = 1;
        v.x_asel = 32'h8; v.x_bsel = 32'h10; v.x_valid = 1; v.x_opa = 32'h11; v.x_opb = 32'h22; v.x_sd = 32'h22;
        vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rt = 5; v.ui = 1; v.imm = 32'hFFFF_FFF0; v.rd = 1; v.rw = 1;
        v.x_bsel = 32'h20; v.x_valid = 1; v.x_opb = 32'hFFFF_FFF0; v.x_sd = 32'h55;
        vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rs = 7; v.rd = 2; v.rw = 1;
        v.ew = 1; v.erd = 7; v.ed = 32'hA; v.mwe = 1; v.mrd = 7; v.md = 32'hB;
        v.x_asel = 32'h80; v.x_valid = 1; v.x_opa = 32'hA;
        vt.push_back(v);
        v.ew = 0; v.x_opa = 32'hB; vt.push_back(v);
        v = ld; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1; v.x_opa = 32'h101;
        v.x_opb = 32'h202; v.x_sd = 32'h202; vt.push_back(v);
        v = dep; v.x_asel = 32'h200; v.x_bsel = 32'h8; v.x_stall = 1; v.x_cnt = 1; vt.push_back(v);
        v = dep; v.mwe = 1; v.mrd = 9; v.md = 32'hC0DE; v.x_asel = 32'h200; v.x_bsel = 32'h8;
        v.x_valid = 1; v.x_opa = 32'hC0DE; v.x_opb = 32'h11; v.x_sd = 32'h11; v.x_cnt = 1; vt.push_back(v);
        v = ld; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1; v.x_opa = 32'h101;
        v.x_opb = 32'h202; v.x_sd = 32'h202; v.x_cnt = 1; vt.push_back(v);
        v = dep; v.fl = 1; v.x_asel = 32'h200; v.x_bsel = 32'h8; v.x_cnt = 1; vt.push_back(v);
        v = ld; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1; v.x_opa = 32'h101;
        v.x_opb = 32'h202; v.x_sd = 32'h202; v.x_cnt = 1; vt.push_back(v);
        v = dep; v.rst = 1; v.x_asel = 32'h200; v.x_bsel = 32'h8; v.x_stall = 1; vt.push_back(v);
        v = dep; v.x_asel = 32'h200; v.x_bsel = 32'h8; v.x_valid = 1; v.x_opa = 32'h99;
        v.x_opb = 32'h11; v.x_sd = 32'h11; vt.push_back(v);
        v = ld; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1; v.x_opa = 32'h101;
        v.x_opb = 32'h202; v.x_sd = 32'h202; vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rs = 1; v.rt = 9; v.ui = 1; v.imm = 32'h40; v.rd = 3; v.rw = 1;
        v.x_asel = 32'h2; v.x_bsel = 32'h200; v.x_valid = 1; v.x_opa = 32'h101; v.x_opb = 32'h40;
        v.x_sd = 32'h99; vt.push_back(v);
        v = ld; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1; v.x_opa = 32'h101;
        v.x_opb = 32'h202; v.x_sd = 32'h202; vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rs = 1; v.rt = 9; v.ui = 1; v.mw = 1; v.imm = 32'h8;
        v.x_asel = 32'h2; v.x_bsel = 32'h200; v.x_stall = 1; v.x_cnt = 1; vt.push_back(v);
        v.x_stall = 0; v.x_valid = 1; v.x_opa = 32'h101; v.x_opb = 32'h8; v.x_sd = 32'h99; vt.push_back(v);
        v = ld; v.rd = 0; v.rw = 0; v.x_asel = 32'h2; v.x_bsel = 32'h4; v.x_valid = 1;
        v.x_opa = 32'h101; v.x_opb = 32'h202; v.x_sd = 32'h202; v.x_cnt = 1; vt.push_back(v);
        v = '{default: '0}; v.v = 1; v.rd = 4; v.rw = 1; v.x_valid = 1; v.x_cnt = 1; vt.push_back(v);

        foreach (vt[i]) begin
            apply(vt[i]);
            #1;
            chk($sformatf("t%0d_asel", i), asel, vt[i].x_asel);
            chk($sformatf("t%0d_bsel", i), bsel, vt[i].x_bsel);
            chk($sformatf("t%0d_stall", i), stall, vt[i].x_stall);
            run_cycle();
            chk($sformatf("t%0d_ex_valid", i), ex_valid, vt[i].x_valid);
            chk($sformatf("t%0d_stall_count", i), stall_count, vt[i].x_cnt);
            if (vt[i].x_valid) begin
                chk($sformatf("t%0d_ex_opa", i), ex_opa, vt[i].x_opa);
                chk($sformatf("t%0d_ex_opb", i), ex_opb, vt[i].x_opb);
                chk($sformatf("t%0d_ex_store_data", i), ex_store_data, vt[i].x_sd);
            end
        end

        for (int n = 0; n < 3000; n++) begin
            v = '{default: '0};
            v.rst = ($urandom_range(0, 199) == 0);
            v.fl = ($urandom_range(0, 9) == 0);
            v.v = ($urandom_range(0, 7) != 0);
            v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7));
            v.rd = 5'($urandom_range(0, 7)); v.imm = $urandom; v.op = 4'($urandom);
            v.ui = 1'($urandom); v.mr = ($urandom_range(0, 2) == 0); v.mw = ($urandom_range(0, 3) == 0);
            v.rw = 1'($urandom); v.ew = 1'($urandom); v.erd = 5'($urandom_range(0, 7)); v.ed = $urandom;
            v.mwe = 1'($urandom); v.mrd = 5'($urandom_range(0, 7)); v.md = $urandom;
            regs[$urandom_range(1, 31)] = $urandom;
            junk_a = $urandom; junk_b = $urandom;
            apply(v);
            run_cycle();
        end

        v = '{default: '0}; v.rst = 1'b1; apply(v); run_cycle();
        for (int n = 0; n < int'(CMAX) + 5; n++) begin
            apply(ld);  run_cycle();
            apply(dep); run_cycle();
        end
        chk("sat_stall_count", stall_count, CMAX);

        apply(ld); run_cycle();
        v = dep; v.rst = 1'b1; apply(v); run_cycle();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ctrl", {ex_mem_read, ex_mem_write, ex_reg_write}, 0);
        chk("rst_ex_data", {ex_opa, ex_opb}, 0);
        chk("rst_ex_sd_rd_op", {ex_store_data, ex_rd, ex_aluop}, 0);
        chk("rst_stall_count", stall_count, 0);
        v = dep; apply(v); #1;
        chk("rst_stall_after", stall, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
